// File: rtl/dso_pkg.sv
`default_nettype none
// ============================================================================
// Module : dso_pkg
// Shared opcodes, ack codes and frame-assembly state encoding for the host link.
// Rev    : 1.0
// ============================================================================
package dso_pkg;

  localparam logic [7:0] DUMP_CH     = 8'h01;
  localparam logic [7:0] CFG_GAIN    = 8'h02;
  localparam logic [7:0] TRIG_LVL    = 8'h03;
  localparam logic [7:0] TRIG_POS    = 8'h04;
  localparam logic [7:0] SET_DEC     = 8'h05;
  localparam logic [7:0] TRIG_CFG    = 8'h06;
  localparam logic [7:0] RD_TRIG_CFG = 8'h07;
  localparam logic [7:0] EEP_WR      = 8'h08;
  localparam logic [7:0] EEP_RD      = 8'h09;

  localparam logic [7:0] POS_ACK     = 8'hA5;
  localparam logic [7:0] NEG_ACK     = 8'hEE;

  typedef enum logic [1:0] {
    WAIT_HI  = 2'd0,
    WAIT_MID = 2'd1,
    WAIT_LO  = 2'd2
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_trcv.sv
`default_nettype none
// ============================================================================
// Module : uart_trcv
// 8N1 bit-level receiver and transmitter with independent baud counters.
// Rev    : 1.0
// ============================================================================
module uart_trcv
  import dso_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       rx_ferr,
  output logic       rx_start,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int            c_cw        = $clog2(BAUD_DIV);
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(BAUD_DIV - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(BAUD_DIV / 2 - 1);

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic            r_rx_busy, r_rx_rdy, r_rx_ferr;
  logic [c_cw-1:0] r_rx_cnt;
  logic [3:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_edge;

  logic            r_tx_busy;
  logic [c_cw-1:0] r_tx_cnt;
  logic [3:0]      r_tx_bit;
  logic [9:0]      r_tx_shift;

  assign w_rx_edge = !r_rx_busy && r_rx_prev && !r_rx_sync;

  // r_rx_bit: 0 = start recheck at half bit, 1..8 = data, 9 = stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_rx_rdy  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (w_rx_edge) begin
        r_rx_busy <= 1'b1;
        r_rx_cnt  <= c_half_last;
        r_rx_bit  <= '0;
      end else if (r_rx_busy) begin
        if (r_rx_cnt != '0) begin
          r_rx_cnt <= r_rx_cnt - 1'b1;
        end else begin
          r_rx_cnt <= c_bit_last;
          r_rx_bit <= r_rx_bit + 4'd1;
          if (r_rx_bit == 4'd0) begin
            if (r_rx_sync) r_rx_busy <= 1'b0;
          end else if (r_rx_bit == 4'd9) begin
            r_rx_busy <= 1'b0;
            r_rx_rdy  <= r_rx_sync;
            r_rx_ferr <= !r_rx_sync;
          end else begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          end
        end
      end
    end
  end

  // Shifter idles all-ones so TX sits high, including straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else if (!r_tx_busy) begin
      if (trmt) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, tx_data, 1'b0};
        r_tx_cnt   <= c_bit_last;
        r_tx_bit   <= '0;
      end
    end else if (r_tx_cnt != '0) begin
      r_tx_cnt <= r_tx_cnt - 1'b1;
    end else if (r_tx_bit == 4'd9) begin
      r_tx_busy <= 1'b0;
    end else begin
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      r_tx_bit   <= r_tx_bit + 4'd1;
      r_tx_cnt   <= c_bit_last;
    end
  end

  assign TX       = r_tx_shift[0];
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);
  assign rx_byte  = r_rx_shift;
  assign rx_rdy   = r_rx_rdy;
  assign rx_ferr  = r_rx_ferr;
  assign rx_start = w_rx_edge;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_slv.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_slv
// Host-link slave: assembles 3-byte RX frames into a 24-bit command, sends responses.
// Rev    : 1.0
// ============================================================================
module uart_cmd_slv
  import dso_pkg::*;
#(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frame_err
);

  localparam int              c_tw      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tw-1:0] c_tmo_lim = c_tw'(TIMEOUT_CYC);

  logic [7:0]      w_rx_byte;
  logic            w_rx_rdy, w_rx_ferr, w_rx_start, w_tmo;
  frame_state_t    r_state, w_nxt_state;
  logic [23:0]     r_cmd;
  logic            r_cmd_rdy, r_frame_err;
  logic [c_tw-1:0] r_tmo_cnt;

  uart_trcv #(.BAUD_DIV(BAUD_DIV)) u_trcv (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .rx_byte  (w_rx_byte),
    .rx_rdy   (w_rx_rdy),
    .rx_ferr  (w_rx_ferr),
    .rx_start (w_rx_start),
    .tx_data  (resp),
    .trmt     (send_resp),
    .tx_done  (resp_sent),
    .tx_busy  (tx_busy)
  );

  assign w_tmo = (r_state != WAIT_HI) && (r_tmo_cnt == c_tmo_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_HI;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    if (w_rx_ferr) begin
      w_nxt_state = WAIT_HI;
    end else if (w_rx_rdy) begin
      case (r_state)
        WAIT_HI:  w_nxt_state = WAIT_MID;
        WAIT_MID: w_nxt_state = WAIT_LO;
        default:  w_nxt_state = WAIT_HI;
      endcase
    end else if (w_tmo) begin
      w_nxt_state = WAIT_HI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_rx_ferr | (w_tmo & ~w_rx_rdy);

      if (r_state == WAIT_HI || w_rx_start || w_rx_rdy || w_tmo) r_tmo_cnt <= '0;
      else                                                       r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (w_rx_rdy) begin
        case (r_state)
          WAIT_HI:  r_cmd[23:16] <= w_rx_byte;
          WAIT_MID: r_cmd[15:8]  <= w_rx_byte;
          WAIT_LO:  r_cmd[7:0]   <= w_rx_byte;
          default:  r_cmd        <= r_cmd;
        endcase
      end

      // Completing a frame takes priority over a coincident consume
      if (w_rx_rdy && r_state == WAIT_LO)                          r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (w_rx_rdy && r_state == WAIT_HI))    r_cmd_rdy <= 1'b0;
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_slv.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_slv
// Directed self-checking bench for uart_cmd_slv (short baud and timeout).
// Rev    : 1.0
// ============================================================================
module tb_uart_cmd_slv;

  localparam int BD  = 16;
  localparam int TMO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int sent_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_slv #(.BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frame_err   (frame_err)
  );

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (resp_sent) sent_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = f[i];
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  // Returns at the negedge during which the receiver's byte-ready pulse is high
  task automatic wait_rx_rdy(output bit found);
    found = 1'b0;
    for (int k = 0; k < 12 * BD; k++) begin
      @(negedge clk);
      if (dut.u_trcv.rx_rdy) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_vec++; if (TX !== 1'b1)      begin n_err++; $display("FAIL rst_tx: got %b want 1", TX); end
    n_vec++; if (cmd !== 24'h0)    begin n_err++; $display("FAIL rst_cmd: got %h want 000000", cmd); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
    n_vec++; if (resp_sent !== 1'b0) begin n_err++; $display("FAIL rst_resp_sent: got %b want 0", resp_sent); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_frame();
    bit found;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    fork
      send_byte(8'h05, 1'b1);
      begin
        wait_rx_rdy(found);
        n_vec++; if (!found) begin n_err++; $display("FAIL frm_rx_rdy_timeout: got none want pulse"); end
        n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL frm_rdy_early: got %b want 0", cmd_rdy); end
        @(negedge clk);
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL frm_rdy_next: got %b want 1", cmd_rdy); end
      end
    join
    idle(2);
    n_vec++; if (cmd !== 24'h020005) begin n_err++; $display("FAIL frm_cmd: got %h want 020005", cmd); end
    n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL frm_ferr: got %0d want 0", ferr_cnt); end
    pulse_clr();
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL frm_clr: got %b want 0", cmd_rdy); end
  endtask

  task automatic test_clr_collision();
    bit found;
    send_byte(8'h06, 1'b1);
    send_byte(8'hA0, 1'b1);
    fork
      send_byte(8'h5F, 1'b1);
      begin
        wait_rx_rdy(found);
        n_vec++; if (!found) begin n_err++; $display("FAIL col_rx_rdy_timeout: got none want pulse"); end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL col_set_wins: got %b want 1", cmd_rdy); end
      end
    join
    idle(4);
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL col_hold: got %b want 1", cmd_rdy); end
    n_vec++; if (cmd !== 24'h06A05F) begin n_err++; $display("FAIL col_cmd: got %h want 06A05F", cmd); end
    pulse_clr();
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL col_later_clr: got %b want 0", cmd_rdy); end
  endtask

  task automatic test_timeout();
    int base;
    base = ferr_cnt;
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(100);
    n_vec++; if (ferr_cnt !== base) begin n_err++; $display("FAIL tmo_early: got %0d want %0d", ferr_cnt, base); end
    idle(TMO);
    n_vec++; if (ferr_cnt !== base + 1) begin n_err++; $display("FAIL tmo_pulse: got %0d want %0d", ferr_cnt, base + 1); end
    n_vec++; if (cmd !== 24'h03005F) begin n_err++; $display("FAIL tmo_cmd_kept: got %h want 03005F", cmd); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL tmo_rdy_kept: got %b want 0", cmd_rdy); end
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h2E, 1'b1);
    idle(2);
    n_vec++; if (cmd !== 24'h03002E) begin n_err++; $display("FAIL tmo_resync_cmd: got %h want 03002E", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL tmo_resync_rdy: got %b want 1", cmd_rdy); end
    n_vec++; if (ferr_cnt !== base + 1) begin n_err++; $display("FAIL tmo_extra_ferr: got %0d want %0d", ferr_cnt, base + 1); end
    pulse_clr();
  endtask

  task automatic test_bad_stop();
    int base;
    base = ferr_cnt;
    send_byte(8'h05, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(4);
    n_vec++; if (ferr_cnt !== base + 1) begin n_err++; $display("FAIL stop_ferr: got %0d want %0d", ferr_cnt, base + 1); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL stop_rdy: got %b want 0", cmd_rdy); end
    send_byte(8'h05, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(2);
    n_vec++; if (cmd !== 24'h051234) begin n_err++; $display("FAIL stop_next_cmd: got %h want 051234", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL stop_next_rdy: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_tx();
    logic [9:0] exp_bits;
    int first_sent;
    int sent_base;
    exp_bits   = {1'b1, 8'hA5, 1'b0};
    first_sent = -1;
    sent_base  = sent_cnt;
    @(negedge clk);
    resp = 8'hA5;
    send_resp = 1'b1;
    for (int k = 1; k <= 11 * BD; k++) begin
      @(negedge clk);
      if (k == 1) begin
        send_resp = 1'b0;
        n_vec++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL tx_busy_rise: got %b want 1", tx_busy); end
      end
      if (k == 3 * BD + 2) begin resp = 8'h00; send_resp = 1'b1; end
      if (k == 3 * BD + 3) send_resp = 1'b0;
      if ((k % BD) == BD / 2 && (k / BD) < 10) begin
        n_vec++;
        if (TX !== exp_bits[k / BD]) begin
          n_err++; $display("FAIL tx_bit%0d: got %b want %b", k / BD, TX, exp_bits[k / BD]);
        end
      end
      if (resp_sent && first_sent < 0) first_sent = k;
      if (k == 10 * BD + 1) begin
        n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL tx_busy_fall: got %b want 0", tx_busy); end
      end
      if (k == 10 * BD + BD / 2) begin
        n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL tx_no_queue: got %b want 1", TX); end
      end
    end
    n_vec++; if (first_sent !== 10 * BD) begin n_err++; $display("FAIL tx_sent_time: got %0d want %0d", first_sent, 10 * BD); end
    n_vec++; if (sent_cnt !== sent_base + 1) begin n_err++; $display("FAIL tx_sent_count: got %0d want %0d", sent_cnt - sent_base, 1); end
  endtask

  task automatic test_reset_abort();
    int base;
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    @(negedge clk);
    resp = 8'hEE;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    idle(BD / 2);
    n_vec++; if (TX !== 1'b0) begin n_err++; $display("FAIL abort_pre_tx: got %b want 0", TX); end
    n_vec++; if (cmd !== 24'h040134) begin n_err++; $display("FAIL abort_pre_cmd: got %h want 040134", cmd); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL abort_tx: got %b want 1", TX); end
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL abort_rdy: got %b want 0", cmd_rdy); end
    n_vec++; if (cmd !== 24'h0) begin n_err++; $display("FAIL abort_cmd: got %h want 000000", cmd); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", tx_busy); end
    idle(3);
    rst_n = 1'b1;
    idle(5);
    base = ferr_cnt;
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(2);
    n_vec++; if (cmd !== 24'h040134) begin n_err++; $display("FAIL post_rst_cmd: got %h want 040134", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_rdy: got %b want 1", cmd_rdy); end
    n_vec++; if (ferr_cnt !== base) begin n_err++; $display("FAIL post_rst_ferr: got %0d want %0d", ferr_cnt, base); end
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL post_rst_tx_idle: got %b want 1", TX); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_clr_collision();
    test_timeout();
    test_bad_stop();
    test_tx();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
